// File: rtl/serial_rx_deserializer.sv
// Serial-in, parallel-out receiver. It takes idle-high frames (start 0,
// WIDTH data bits LSB first, stop 1) and presents each word with a
// valid/ready handshake. It also pulses flags for framing errors and overruns.
module serial_rx_deserializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;

    // State, counters, shift register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state logic: bit timing, sampling, word hand-off and flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        // A pending word is consumed by ready. The STOP branch can reassert valid.
        dv_d    = dv_q & ~data_ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!serial_in) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Entered on edge t0, so the counter reads H-1 at edge t0+H.
            START: begin
                if (cnt_q == CW'(H - 1)) begin
                    cnt_d   = '0;
                    state_d = serial_in ? IDLE : DATA;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Each later sample point comes one full bit period after the previous one.
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    for (int i = 0; i < WIDTH - 1; i++)
                        shreg_d[i] = shreg_q[i+1];
                    shreg_d[WIDTH-1] = serial_in;
                    if (bit_q == BW'(WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (serial_in) begin
                        state_d = IDLE;
                        if (!dv_q || data_ready) begin
                            dout_d = shreg_q;
                            dv_d   = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A held-low (break) line must not look like a new start bit.
            WAIT_HIGH: begin
                if (serial_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign busy       = (state_q != IDLE);

endmodule
